// File: rtl/mdio_pkg.sv
// mdio_pkg: shared constants and state type for the MDIO Clause 22 responder.
package mdio_pkg;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam int unsigned PHYAD_W  = 5;
    localparam int unsigned REGAD_W  = 5;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned TA_LEN   = 2;
    localparam int unsigned NUM_REGS = 32;

    typedef enum logic [2:0] {
        StIdle,
        StSt,
        StOp,
        StPhyad,
        StRegad,
        StTa,
        StData
    } mdio_state_e;

endpackage

// File: rtl/mdio_edge_sync.sv
// mdio_edge_sync: 2-flop synchronizer for MDC and MDIO plus an MDC rising-edge pulse.
module mdio_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic mdc,
    input  logic mdio_i,
    output logic mdio_s,
    output logic mdc_rise
);

    logic [2:0] mdc_q;
    logic [1:0] mdio_q;

    // Shift raw pins into the clk domain; MDC history resets high so reset release never
    // fabricates a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_q  <= 3'b111;
            mdio_q <= 2'b11;
        end else begin
            mdc_q  <= {mdc_q[1:0], mdc};
            mdio_q <= {mdio_q[0], mdio_i};
        end
    end

    assign mdio_s   = mdio_q[1];
    assign mdc_rise = mdc_q[1] & ~mdc_q[2];

endmodule

// File: rtl/mdio_slave_responder.sv
// mdio_slave_responder: Clause 22 MDIO responder (PHY side) owning a 32x16 register file.
// MDC/MDIO are oversampled in the clk domain; MDC is never used as a clock.
// Build option: define MDIO_BCAST_EN to also accept PHY address 0 for write frames.
module mdio_slave_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter int unsigned PRE_LEN  = 32,
    parameter logic [31:0] RO_MASK  = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        loc_wr_en,
    input  logic [4:0]  loc_wr_addr,
    input  logic [15:0] loc_wr_data,
    output logic        reg_wr_valid,
    output logic [4:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data,
    output logic        rd_done,
    output logic        frame_err
);

    localparam int unsigned       ONES_W    = (PRE_LEN == 0) ? 1 : $clog2(PRE_LEN + 1);
    localparam logic [ONES_W-1:0] PRE_CNT   = ONES_W'(PRE_LEN);
    localparam logic [3:0]        OP_LAST   = 4'd1;
    localparam logic [3:0]        PHY_LAST  = 4'(PHYAD_W - 1);
    localparam logic [3:0]        REG_LAST  = 4'(REGAD_W - 1);
    localparam logic [3:0]        TA_LAST   = 4'(TA_LEN - 1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_W - 1);

    logic mdio_s;
    logic mdc_rise;

    mdio_edge_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .mdc      (mdc),
        .mdio_i   (mdio_i),
        .mdio_s   (mdio_s),
        .mdc_rise (mdc_rise)
    );

    mdio_state_e         state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic                op_rd_q, op_rd_d;
    logic [4:0]          fld_q, fld_d;
    logic [4:0]          regad_q, regad_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                oe_q, oe_d;
    logic                o_q, o_d;
    logic                wr_valid_q, wr_valid_d;
    logic [4:0]          wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                rd_done_q, rd_done_d;
    logic                err_q, err_d;
    logic                mdio_we;
    logic                phy_ok;
    logic [4:0]          fld_nxt;
    logic [DATA_W-1:0]   wr_word;
    logic [DATA_W-1:0]   rf_q [NUM_REGS];

    assign fld_nxt = {fld_q[3:0], mdio_s};
    assign wr_word = {shift_q[DATA_W-2:0], mdio_s};

`ifdef MDIO_BCAST_EN
    // Address 0 is a write-only broadcast; reads to it stay silent.
    assign phy_ok = (fld_nxt == PHY_ADDR) || ((fld_nxt == 5'd0) && !op_rd_q);
`else
    assign phy_ok = (fld_nxt == PHY_ADDR);
`endif

    // Frame decoder: advances one bit per synchronized MDC rising edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ones_d     = ones_q;
        op_rd_d    = op_rd_q;
        fld_d      = fld_q;
        regad_d    = regad_q;
        shift_d    = shift_q;
        oe_d       = oe_q;
        o_d        = o_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = 1'b0;
        rd_done_d  = 1'b0;
        err_d      = 1'b0;
        mdio_we    = 1'b0;
        if (mdc_rise) begin
            unique case (state_q)
                StIdle: begin
                    if (mdio_s) begin
                        if (ones_q != PRE_CNT) ones_d = ones_q + 1'b1;
                    end else begin
                        ones_d = '0;
                        if (ones_q >= PRE_CNT) begin
                            state_d = StSt;
                            cnt_d   = '0;
                        end
                    end
                end
                StSt: begin
                    if (mdio_s) begin
                        state_d = StOp;
                        cnt_d   = '0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
                StOp: begin
                    fld_d = fld_nxt;
                    if (cnt_q == OP_LAST) begin
                        cnt_d = '0;
                        case ({fld_q[0], mdio_s})
                            OP_READ: begin
                                op_rd_d = 1'b1;
                                state_d = StPhyad;
                            end
                            OP_WRITE: begin
                                op_rd_d = 1'b0;
                                state_d = StPhyad;
                            end
                            default: begin
                                err_d   = 1'b1;
                                state_d = StIdle;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StPhyad: begin
                    fld_d = fld_nxt;
                    if (cnt_q == PHY_LAST) begin
                        cnt_d   = '0;
                        state_d = phy_ok ? StRegad : StIdle;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StRegad: begin
                    fld_d = fld_nxt;
                    if (cnt_q == REG_LAST) begin
                        cnt_d   = '0;
                        regad_d = fld_nxt;
                        // Snapshot now so later local writes cannot alter the frame.
                        if (op_rd_q) shift_d = rf_q[fld_nxt];
                        state_d = StTa;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StTa: begin
                    if (cnt_q == TA_LAST) begin
                        cnt_d   = '0;
                        state_d = StData;
                        if (op_rd_q) begin
                            o_d     = shift_q[DATA_W-1];
                            shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (op_rd_q) begin
                            oe_d = 1'b1;
                            o_d  = 1'b0;
                        end
                    end
                end
                StData: begin
                    if (op_rd_q) begin
                        if (cnt_q == DATA_LAST) begin
                            oe_d      = 1'b0;
                            o_d       = 1'b1;
                            rd_done_d = 1'b1;
                            state_d   = StIdle;
                        end else begin
                            o_d     = shift_q[DATA_W-1];
                            shift_d = {shift_q[DATA_W-2:0], 1'b0};
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end else begin
                        shift_d = wr_word;
                        if (cnt_q == DATA_LAST) begin
                            state_d = StIdle;
                            if (!RO_MASK[regad_q]) begin
                                mdio_we    = 1'b1;
                                wr_valid_d = 1'b1;
                                wr_addr_d  = regad_q;
                                wr_data_d  = wr_word;
                            end
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Decoder state and registered pad/pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ones_q     <= '0;
            op_rd_q    <= 1'b0;
            fld_q      <= '0;
            regad_q    <= '0;
            shift_q    <= '0;
            oe_q       <= 1'b0;
            o_q        <= 1'b1;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ones_q     <= ones_d;
            op_rd_q    <= op_rd_d;
            fld_q      <= fld_d;
            regad_q    <= regad_d;
            shift_q    <= shift_d;
            oe_q       <= oe_d;
            o_q        <= o_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_done_q  <= rd_done_d;
            err_q      <= err_d;
        end
    end

    // Register file; the local write is issued last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else begin
            if (mdio_we) rf_q[regad_q] <= wr_word;
            if (loc_wr_en) rf_q[loc_wr_addr] <= loc_wr_data;
        end
    end

    assign mdio_oe      = oe_q;
    assign mdio_o       = o_q;
    assign reg_wr_valid = wr_valid_q;
    assign reg_wr_addr  = wr_addr_q;
    assign reg_wr_data  = wr_data_q;
    assign rd_done      = rd_done_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_mdio_slave_responder.sv
// tb_mdio_slave_responder: directed frames against a frame-level model of the responder.
module tb_mdio_slave_responder;

    localparam logic [4:0]  PHY = 5'd1;
    localparam int          PRE = 32;
    localparam logic [31:0] RO  = 32'h0000_0002;
`ifdef MDIO_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mdc = 1'b0;
    logic        mst = 1'b1;
    logic        loc_wr_en = 1'b0;
    logic [4:0]  loc_wr_addr = 5'd0;
    logic [15:0] loc_wr_data = 16'd0;
    logic        mdio_o, mdio_oe, reg_wr_valid, rd_done, frame_err;
    logic [4:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;
    logic        mdio_bus;

    // Open-drain style bus: responder drive overrides the master / pull-up.
    assign mdio_bus = mdio_oe ? mdio_o : mst;

    mdio_slave_responder #(
        .PHY_ADDR (PHY),
        .PRE_LEN  (PRE),
        .RO_MASK  (RO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mdc          (mdc),
        .mdio_i       (mdio_bus),
        .mdio_o       (mdio_o),
        .mdio_oe      (mdio_oe),
        .loc_wr_en    (loc_wr_en),
        .loc_wr_addr  (loc_wr_addr),
        .loc_wr_data  (loc_wr_data),
        .reg_wr_valid (reg_wr_valid),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .rd_done      (rd_done),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cnt_wr = 0;
    int          cnt_rd = 0;
    int          cnt_err = 0;
    logic [4:0]  last_wa = 5'd0;
    logic [15:0] last_wd = 16'd0;
    logic [15:0] rd_word = 16'd0;
    logic        chk = 1'b0;
    int          chk_idx = 0;
    logic        exp_oe = 1'b0;
    logic        exp_o = 1'b1;

    logic [15:0] mdl_rf [32];
    int          mdl_tail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Compare process: pulse bookkeeping every cycle, pad check inside each bit window.
    always @(negedge clk) begin
        if (reg_wr_valid) begin
            cnt_wr++;
            last_wa = reg_wr_addr;
            last_wd = reg_wr_data;
        end
        if (rd_done) cnt_rd++;
        if (frame_err) cnt_err++;
        if (chk) begin
            check($sformatf("bit%0d_oe", chk_idx), 32'(mdio_oe), 32'(exp_oe));
            check($sformatf("bit%0d_o", chk_idx), 32'(mdio_o), 32'(exp_o));
            if (chk_idx >= 15 && chk_idx <= 30) rd_word[30-chk_idx] = mdio_o;
        end
    end

    // One MDC period: master changes data on the falling edge, DUT samples on the rise.
    task automatic send_bit(input logic b, input bit do_chk, input int idx, input logic eoe,
                            input logic eo, input bit loc, input bit do_rst);
        @(posedge clk);
        #2 mdc = 1'b0;
        mst = b;
        repeat (5) @(posedge clk);
        #2 mdc = 1'b1;
        repeat (2) @(posedge clk);
        #2 loc_wr_en = loc;
        @(posedge clk);
        #2 loc_wr_en = 1'b0;
        @(posedge clk);
        #2;
        chk_idx = idx;
        exp_oe  = eoe;
        exp_o   = eo;
        chk     = do_chk;
        if (do_rst) begin
            @(negedge clk);
            #1 chk = 1'b0;
            rst_n = 1'b0;
            #1;
            check("rst_mid_oe", 32'(mdio_oe), 32'd0);
            check("rst_mid_o", 32'(mdio_o), 32'd1);
            mdc = 1'b0;
            mst = 1'b1;
            repeat (3) @(posedge clk);
            #2 rst_n = 1'b1;
        end else begin
            @(posedge clk);
            #2 chk = 1'b0;
        end
    endtask

    task automatic loc_write(input logic [4:0] a, input logic [15:0] d);
        @(posedge clk);
        #2 loc_wr_addr = a;
        loc_wr_data = d;
        loc_wr_en   = 1'b1;
        @(posedge clk);
        #2 loc_wr_en = 1'b0;
        mdl_rf[a] = d;
    endtask

    // Sends preamble + one 32-bit frame; the model decides what the responder must do.
    task automatic run_frame(input string tag, input int pre, input logic [1:0] st,
                             input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                             input logic [15:0] wd, input bit collide, input logic [15:0] loc_d,
                             input int rst_at);
        logic [31:0] bits;
        logic [15:0] rdata;
        int          abort, t, wr0, rd0, err0;
        bit          answered, do_wr, do_err, accept;
        bits     = {st, op, phy, ra, (op == 2'b10) ? 18'h3FFFF : {2'b10, wd}};
        abort    = 32;
        answered = 1'b0;
        do_wr    = 1'b0;
        do_err   = 1'b0;
        rdata    = 16'd0;
        accept   = (phy == PHY) || (BCAST && phy == 5'd0 && op == 2'b01);
        if (mdl_tail + pre < PRE) begin
            abort = 0;
        end else if (st != 2'b01) begin
            do_err = 1'b1;
            abort  = 1;
        end else if (op != 2'b10 && op != 2'b01) begin
            do_err = 1'b1;
            abort  = 3;
        end else if (!accept) begin
            abort = 8;
        end else if (op == 2'b10) begin
            answered = 1'b1;
            rdata    = mdl_rf[ra];
        end else begin
            do_wr = !RO[ra];
            if (do_wr) mdl_rf[ra] = wd;
        end
        if (collide) mdl_rf[ra] = loc_d;
        t = 0;
        if (abort < 32) begin
            for (int j = 31; j > abort; j--) begin
                if (!bits[31-j]) break;
                t++;
            end
        end
        mdl_tail = t;

        wr0 = cnt_wr;
        rd0 = cnt_rd;
        err0 = cnt_err;
        loc_wr_addr = ra;
        loc_wr_data = loc_d;
        for (int i = 0; i < pre; i++) send_bit(1'b1, 1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 32; j++) begin
            logic eoe, eo;
            eoe = answered && j >= 14 && j <= 30;
            eo  = !eoe ? 1'b1 : ((j == 14) ? 1'b0 : rdata[30-j]);
            send_bit(bits[31-j], 1'b1, j, eoe, eo, collide && j == 31, rst_at == j);
            if (rst_at == j) break;
        end
        if (rst_at >= 0) begin
            for (int r = 0; r < 32; r++) mdl_rf[r] = 16'd0;
            mdl_tail = 0;
        end
        check({tag, "_wr_cnt"}, 32'(cnt_wr - wr0), 32'(do_wr));
        check({tag, "_rd_cnt"}, 32'(cnt_rd - rd0), 32'(answered && rst_at < 0));
        check({tag, "_err_cnt"}, 32'(cnt_err - err0), 32'(do_err));
        if (do_wr) begin
            check({tag, "_wr_addr"}, 32'(last_wa), 32'(ra));
            check({tag, "_wr_data"}, 32'(last_wd), 32'(wd));
        end
        if (answered && rst_at < 0) check({tag, "_rd_word"}, 32'(rd_word), 32'(rdata));
    endtask

    initial begin
        int e0;
        for (int r = 0; r < 32; r++) mdl_rf[r] = 16'd0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_oe", 32'(mdio_oe), 32'd0);
        check("rst_o", 32'(mdio_o), 32'd1);
        check("rst_wr_valid", 32'(reg_wr_valid), 32'd0);
        check("rst_wr_addr", 32'(reg_wr_addr), 32'd0);
        check("rst_wr_data", 32'(reg_wr_data), 32'd0);
        check("rst_rd_done", 32'(rd_done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;

        run_frame("wr4", 32, 2'b01, 2'b01, 5'd1, 5'd4, 16'hA5C3, 1'b0, 16'h0, -1);
        check("wr4_lit_addr", 32'(last_wa), 32'd4);
        check("wr4_lit_data", 32'(last_wd), 32'hA5C3);
        run_frame("rd4", 32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, 1'b0, 16'h0, -1);
        check("rd4_lit", 32'(rd_word), 32'hA5C3);
        run_frame("rd_phy2", 32, 2'b01, 2'b10, 5'd2, 5'd4, 16'h0, 1'b0, 16'h0, -1);
        run_frame("rd4_again", 32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, 1'b0, 16'h0, -1);
        check("rd4_again_lit", 32'(rd_word), 32'hA5C3);

        e0 = cnt_err;
        run_frame("bad_op", 32, 2'b01, 2'b11, 5'd1, 5'd4, 16'h0, 1'b0, 16'h0, -1);
        check("bad_op_lit", 32'(cnt_err - e0), 32'd1);
        run_frame("bad_st", 32, 2'b00, 2'b01, 5'd1, 5'd4, 16'h0, 1'b0, 16'h0, -1);
        run_frame("pre31", 31, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, 1'b0, 16'h0, -1);

        run_frame("wr_ro", 32, 2'b01, 2'b01, 5'd1, 5'd1, 16'h1234, 1'b0, 16'h0, -1);
        run_frame("rd_ro", 32, 2'b01, 2'b10, 5'd1, 5'd1, 16'h0, 1'b0, 16'h0, -1);
        check("rd_ro_lit", 32'(rd_word), 32'h0000);
        loc_write(5'd1, 16'h4321);
        run_frame("rd_ro_loc", 32, 2'b01, 2'b10, 5'd1, 5'd1, 16'h0, 1'b0, 16'h0, -1);
        check("rd_ro_loc_lit", 32'(rd_word), 32'h4321);

        run_frame("wr5_col", 32, 2'b01, 2'b01, 5'd1, 5'd5, 16'h1111, 1'b1, 16'hBEEF, -1);
        run_frame("rd5", 32, 2'b01, 2'b10, 5'd1, 5'd5, 16'h0, 1'b0, 16'h0, -1);
        check("rd5_lit", 32'(rd_word), 32'hBEEF);

        run_frame("bc_wr", 32, 2'b01, 2'b01, 5'd0, 5'd0, 16'h0F0F, 1'b0, 16'h0, -1);
        run_frame("bc_rd", 32, 2'b01, 2'b10, 5'd0, 5'd0, 16'h0, 1'b0, 16'h0, -1);
        run_frame("rd0", 32, 2'b01, 2'b10, 5'd1, 5'd0, 16'h0, 1'b0, 16'h0, -1);
        check("rd0_lit", 32'(rd_word), BCAST ? 32'h0F0F : 32'h0000);

        run_frame("rst_rd", 32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, 1'b0, 16'h0, 23);
        run_frame("rd4_post", 32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, 1'b0, 16'h0, -1);
        check("rd4_post_lit", 32'(rd_word), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
